// File: rtl/pcs_pkg.sv
// Shared definitions for the PC / return-address-stack block.
// Default sizes and the next-PC source selector.
package pcs_pkg;

    localparam int PCS_WIDTH = 16;
    localparam int PCS_DEPTH = 8;

    // Source of the next PC value, chosen by the priority mux.
    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_IMM  = 3'd1,
        PC_REL  = 3'd2,
        PC_RA   = 3'd3,
        PC_TAIL = 3'd4
    } pc_sel_t;

endpackage

// File: rtl/pcs_ras_stack.sv
// Circular return-address stack.
// When full, a push overwrites the oldest entry and depth saturates.
module pcs_ras_stack
    import pcs_pkg::*;
#(
    parameter int WIDTH = PCS_WIDTH,
    parameter int DEPTH = PCS_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW:0]      cnt;
    logic [AW-1:0]    wr_idx;

    assign wr_idx = ptr + AW'(1);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign depth  = cnt;
    assign top    = empty ? '0 : mem[ptr];

    // Pointer and occupancy; a pop on an empty stack is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= wr_idx;
            if (!full) begin
                cnt <= cnt + (AW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - (AW+1)'(1);
        end
    end

    // Entry storage needs no reset: empty entries are never read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= pushData;
        end
    end

endmodule

// File: rtl/pcs_ras.sv
// Program counter with nested-call return-address stack,
// relative branches, stall and sticky overflow/underflow flags.
module pcs_ras
    import pcs_pkg::*;
#(
    parameter int              WIDTH    = PCS_WIDTH,
    parameter int              DEPTH    = PCS_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   writePC,
    input  logic                   call,
    input  logic                   ret,
    input  logic                   jump,
    input  logic                   branchTaken,
    input  logic                   clearFlags,
    input  logic [WIDTH-1:0]       ImR,
    output logic [WIDTH-1:0]       PC,
    output logic [WIDTH-1:0]       PC_1,
    output logic [WIDTH-1:0]       raTop,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   overflow,
    output logic                   underflow
);

    pc_sel_t          sel;
    logic [WIDTH-1:0] next_pc;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             ovf_evt;
    logic             unf_evt;

    assign PC_1 = PC + WIDTH'(1);

    // A tail call (call+ret together) leaves the stack untouched.
    assign push    = writePC && call && !ret;
    assign pop     = writePC && ret && !call && !empty;
    assign ovf_evt = push && full;
    assign unf_evt = writePC && ret && !call && empty;

    pcs_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .pushData (PC_1),
        .top      (raTop),
        .depth    (depth),
        .full     (full),
        .empty    (empty)
    );

    // Priority selection of the next-PC source.
    always_comb begin
        sel = PC_INC;
        if (call && ret) begin
            sel = PC_TAIL;
        end else if (ret) begin
            sel = empty ? PC_INC : PC_RA;
        end else if (call || jump) begin
            sel = PC_IMM;
        end else if (branchTaken) begin
            sel = PC_REL;
        end
    end

    // Next-PC mux; relative targets wrap modulo 2^WIDTH.
    always_comb begin
        next_pc = PC_1;
        unique case (sel)
            PC_INC:  next_pc = PC_1;
            PC_IMM:  next_pc = ImR;
            PC_TAIL: next_pc = ImR;
            PC_REL:  next_pc = PC + ImR;
            PC_RA:   next_pc = raTop;
            default: next_pc = PC_1;
        endcase
    end

    // PC register; a cleared writePC stalls it.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_PC;
        end else if (writePC) begin
            PC <= next_pc;
        end
    end

    // Sticky flags: a new event in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt || (overflow && !clearFlags);
            underflow <= unf_evt || (underflow && !clearFlags);
        end
    end

endmodule

// File: tb/tb_pcs_ras.sv
// Directed bench for pcs_ras (WIDTH=16, DEPTH=8, RESET_PC=0).
// Expected values are hand-computed from the block behaviour.
module tb_pcs_ras;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         writePC = 1'b0;
    logic         call = 1'b0;
    logic         ret = 1'b0;
    logic         jump = 1'b0;
    logic         branchTaken = 1'b0;
    logic         clearFlags = 1'b0;
    logic [W-1:0] ImR = '0;
    logic [W-1:0] PC;
    logic [W-1:0] PC_1;
    logic [W-1:0] raTop;
    logic [3:0]   depth;
    logic         overflow;
    logic         underflow;

    int n_assert = 0;
    int n_fail   = 0;

    pcs_ras #(
        .WIDTH    (W),
        .DEPTH    (D),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .writePC     (writePC),
        .call        (call),
        .ret         (ret),
        .jump        (jump),
        .branchTaken (branchTaken),
        .clearFlags  (clearFlags),
        .ImR         (ImR),
        .PC          (PC),
        .PC_1        (PC_1),
        .raTop       (raTop),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of control strobes, then sample #1 after the edge.
    task automatic step(input logic wp, input logic c, input logic r,
                        input logic j, input logic b, input logic cf,
                        input logic [W-1:0] imm);
        writePC = wp; call = c; ret = r; jump = j;
        branchTaken = b; clearFlags = cf; ImR = imm;
        @(posedge clk);
        #1;
        writePC = 1'b1; call = 1'b0; ret = 1'b0; jump = 1'b0;
        branchTaken = 1'b0; clearFlags = 1'b0; ImR = '0;
    endtask

    task automatic inc();
        step(1, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_call(input logic [W-1:0] t);
        step(1, 1, 0, 0, 0, 0, t);
    endtask

    task automatic do_ret();
        step(1, 0, 1, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        writePC = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        writePC = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_ratop", 32'(raTop), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);

        // Sequential increment
        for (int i = 1; i <= 5; i++) begin
            inc();
            chk("inc_pc", 32'(PC), 32'(i));
            chk("inc_pc1", 32'(PC_1), 32'(i + 1));
        end
        chk("inc_depth", 32'(depth), 32'd0);

        // Single call / return
        do_call(16'd22);
        chk("call_pc", 32'(PC), 32'd22);
        chk("call_ratop", 32'(raTop), 32'd6);
        chk("call_depth", 32'(depth), 32'd1);
        inc();
        inc();
        chk("body_pc", 32'(PC), 32'd24);
        do_ret();
        chk("ret_pc", 32'(PC), 32'd6);
        chk("ret_depth", 32'(depth), 32'd0);

        // Nested calls
        inc();
        inc();
        chk("pre_nest_pc", 32'(PC), 32'd8);
        do_call(16'd4096);
        chk("n1_ratop", 32'(raTop), 32'd9);
        inc();
        do_call(16'd349);
        chk("n2_ratop", 32'(raTop), 32'd4098);
        inc();
        do_call(16'd100);
        chk("n3_pc", 32'(PC), 32'd100);
        chk("n3_depth", 32'(depth), 32'd3);
        chk("n3_ratop", 32'(raTop), 32'd351);
        do_ret();
        chk("r1_pc", 32'(PC), 32'd351);
        do_ret();
        chk("r2_pc", 32'(PC), 32'd4098);
        do_ret();
        chk("r3_pc", 32'(PC), 32'd9);
        chk("r3_depth", 32'(depth), 32'd0);
        chk("r3_ovf", 32'(overflow), 32'd0);
        chk("r3_unf", 32'(underflow), 32'd0);

        // Overflow: call k at PC=100k pushes 100k+1, first push is lost
        for (int k = 0; k < 9; k++) begin
            do_call(16'(100 * (k + 1)));
            if (k < 8) chk("fill_depth", 32'(depth), 32'(k + 1));
            if (k < 8) chk("fill_ovf", 32'(overflow), 32'd0);
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd8);
        chk("ovf_pc", 32'(PC), 32'd900);
        for (int j = 0; j < 8; j++) begin
            do_ret();
            chk("unwind_pc", 32'(PC), 32'(801 - 100 * j));
        end
        chk("unwind_depth", 32'(depth), 32'd0);
        chk("unwind_ratop", 32'(raTop), 32'h0);
        do_ret();
        chk("unf_pc", 32'(PC), 32'd102);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);

        // Clear both sticky flags
        step(1, 0, 0, 0, 0, 1, '0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        chk("clr_pc", 32'(PC), 32'd103);

        // Stall with call asserted
        step(0, 1, 0, 0, 0, 0, 16'd5);
        step(0, 1, 0, 0, 0, 0, 16'd5);
        chk("stall_pc", 32'(PC), 32'd103);
        chk("stall_depth", 32'(depth), 32'd0);
        chk("stall_ratop", 32'(raTop), 32'h0);

        // Wrap-around
        step(1, 0, 0, 1, 0, 0, 16'hFFFF);
        chk("jump_pc", 32'(PC), 32'hFFFF);
        chk("wrap_pc1", 32'(PC_1), 32'h0);
        inc();
        chk("wrap_pc", 32'(PC), 32'h0);

        // Relative branches
        step(1, 0, 0, 1, 0, 0, 16'd10);
        step(1, 0, 0, 0, 1, 0, 16'hFFFE);
        chk("br_back", 32'(PC), 32'd8);
        step(1, 0, 0, 0, 1, 0, 16'd5);
        chk("br_fwd", 32'(PC), 32'd13);

        // Jump has priority below call
        step(1, 1, 0, 1, 0, 0, 16'd50);
        chk("cj_pc", 32'(PC), 32'd50);
        chk("cj_ratop", 32'(raTop), 32'd14);

        // Tail call
        step(1, 1, 1, 0, 0, 0, 16'd77);
        chk("tail_pc", 32'(PC), 32'd77);
        chk("tail_depth", 32'(depth), 32'd1);
        chk("tail_ratop", 32'(raTop), 32'd14);

        // Reset mid-chain with depth=3 and overflow=1
        for (int k = 0; k < 8; k++) do_call(16'(200 + k));
        for (int k = 0; k < 5; k++) do_ret();
        chk("mid_depth", 32'(depth), 32'd3);
        chk("mid_ovf", 32'(overflow), 32'd1);
        do_reset();
        chk("mid_rst_pc", 32'(PC), 32'h0);
        chk("mid_rst_depth", 32'(depth), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_ratop", 32'(raTop), 32'h0);

        // Set wins over clear
        for (int k = 0; k < 8; k++) do_call(16'(300 + k));
        step(1, 1, 0, 0, 0, 1, 16'd400);
        chk("setwin_ovf", 32'(overflow), 32'd1);
        chk("setwin_ratop", 32'(raTop), 32'd308);
        step(0, 0, 0, 0, 0, 1, '0);
        chk("stallclr_ovf", 32'(overflow), 32'd0);
        chk("stallclr_depth", 32'(depth), 32'd8);
        do_reset();
        step(1, 0, 1, 0, 0, 1, '0);
        chk("setwin_unf", 32'(underflow), 32'd1);
        chk("setwin_unf_pc", 32'(PC), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
